// File: rtl/fragment_packer_if.sv
// Stream bundle between a fragment source, the packer and the beat writer.
// The packer sits on the slave modport; the environment drives the master side.
interface fragment_packer_if #(
    parameter int DATA_WIDTH = 512
);
    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(BYTES);
    localparam int SIZE_W = OFF_W + 1;

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic [OFF_W-1:0]      in_offset;
    logic [SIZE_W-1:0]     in_size;
    logic                  in_last;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [BYTES-1:0]      out_keep;
    logic                  out_last;

    modport slave (
        input  in_valid, in_data, in_offset, in_size, in_last, out_ready,
        output in_ready, out_valid, out_data, out_keep, out_last
    );

    modport master (
        output in_valid, in_data, in_offset, in_size, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_keep, out_last
    );
endinterface

// File: rtl/fragment_packer.sv
// Packs variable-length byte fragments densely into full DATA_WIDTH beats,
// with end-of-stream flush, byte-keep on the final beat and oversize reporting.
module fragment_packer #(
    parameter  int DATA_WIDTH = 512,
    parameter  int COUNT_W    = 32,
    localparam int BYTES      = DATA_WIDTH / 8,
    localparam int OFF_W      = $clog2(BYTES),
    localparam int SIZE_W     = OFF_W + 1
) (
    input  logic               clock,
    input  logic               resetn,
    fragment_packer_if.slave   bus,
    output logic [SIZE_W-1:0]  fill_level,
    output logic [COUNT_W-1:0] beat_count,
    output logic               size_error
);
    typedef enum logic {RUN, FLUSH} state_t;

    localparam logic [SIZE_W-1:0] BYTES_S = SIZE_W'(BYTES);

    state_t                  state, state_nx;
    logic [SIZE_W-1:0]       fill, fill_nx;
    logic [DATA_WIDTH-1:0]   acc, acc_nx;
    logic                    out_valid;
    logic [DATA_WIDTH-1:0]   out_data;
    logic [BYTES-1:0]        out_keep;
    logic                    out_last;

    logic                    out_free, accept, consume, oversize;
    logic [SIZE_W-1:0]       room, eff, nf;
    logic [DATA_WIDTH-1:0]   frag;
    logic [2*DATA_WIDTH-1:0] comb;
    logic                    load;
    logic [DATA_WIDTH-1:0]   load_data;
    logic [BYTES-1:0]        load_keep;
    logic                    load_last;

    function automatic logic [BYTES-1:0] low_bytes(input logic [SIZE_W-1:0] n);
        logic [BYTES-1:0] m;
        for (int i = 0; i < BYTES; i++) m[i] = (i < int'(n));
        return m;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] byte_to_bit(input logic [BYTES-1:0] m);
        logic [DATA_WIDTH-1:0] b;
        for (int i = 0; i < BYTES; i++) b[8*i +: 8] = {8{m[i]}};
        return b;
    endfunction

    assign out_free = !out_valid || bus.out_ready;
    assign consume  = out_valid && bus.out_ready;
    assign accept   = bus.in_valid && bus.in_ready;

    assign room     = BYTES_S - {1'b0, bus.in_offset};
    assign oversize = bus.in_size > room;
    assign eff      = oversize ? room : bus.in_size;
    assign frag     = (bus.in_data >> {bus.in_offset, 3'b000}) & byte_to_bit(low_bytes(eff));
    // Residual bytes above fill are zero, so OR-ing the shifted fragment in is exact.
    assign comb     = {{DATA_WIDTH{1'b0}}, acc} | ({{DATA_WIDTH{1'b0}}, frag} << {fill, 3'b000});
    assign nf       = fill + eff;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        state_nx  = state;
        fill_nx   = fill;
        acc_nx    = acc;
        load      = 1'b0;
        load_data = comb[DATA_WIDTH-1:0];
        load_keep = '1;
        load_last = 1'b0;
        bus.in_ready = (state == RUN) && out_free;

        if (state == RUN && accept) begin
            if (nf >= BYTES_S && !bus.in_last) begin
                load    = 1'b1;
                acc_nx  = comb[2*DATA_WIDTH-1:DATA_WIDTH];
                fill_nx = nf - BYTES_S;
            end else if (bus.in_last && nf != '0 && nf <= BYTES_S) begin
                load      = 1'b1;
                load_keep = low_bytes(nf);
                load_last = 1'b1;
                acc_nx    = '0;
                fill_nx   = '0;
            end else if (bus.in_last && nf > BYTES_S) begin
                load     = 1'b1;
                acc_nx   = comb[2*DATA_WIDTH-1:DATA_WIDTH];
                fill_nx  = nf - BYTES_S;
                state_nx = FLUSH;
            end else if (bus.in_last) begin
                acc_nx  = '0;
                fill_nx = '0;
            end else begin
                acc_nx  = comb[DATA_WIDTH-1:0];
                fill_nx = nf;
            end
        end else if (state == FLUSH && out_free) begin
            load      = 1'b1;
            load_data = acc;
            load_keep = low_bytes(fill);
            load_last = 1'b1;
            acc_nx    = '0;
            fill_nx   = '0;
            state_nx  = RUN;
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!resetn) begin
            state      <= RUN;
            fill       <= '0;
            acc        <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_keep   <= '0;
            out_last   <= 1'b0;
            beat_count <= '0;
            size_error <= 1'b0;
        end else begin
            state <= state_nx;
            fill  <= fill_nx;
            acc   <= acc_nx;
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= load_data;
                out_keep  <= load_keep;
                out_last  <= load_last;
            end else if (consume) begin
                out_valid <= 1'b0;
            end
            if (consume) beat_count <= beat_count + COUNT_W'(1);
            if (accept && oversize) size_error <= 1'b1;
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.out_keep  = out_keep;
    assign bus.out_last  = out_last;
    assign fill_level    = fill;
endmodule

// File: doc/fragment_packer.md
Name: fragment_packer

Overview:
- Parametrised successor to the relational-cache packer, one beat wide at DATA_WIDTH.
- Extracts a variable-length byte fragment (offset, size) from each input beat and appends it densely to an accumulation buffer.
- Emits full DATA_WIDTH beats on a valid/ready stream toward the writer.
- Adds over the previous generation: width generality, input/output backpressure, explicit end-of-stream flush with byte-keep on the final partial beat, and oversize-fragment error reporting.

Parameters:
- DATA_WIDTH, 512, output/input beat width in bits; multiple of 8, power of two, 64..1024. Derived localparams: BYTES = DATA_WIDTH/8; OFF_W = clog2(BYTES); SIZE_W = OFF_W+1.
- COUNT_W, 32, width of the emitted-beat counter.

Ports:
- clock  in  1  sole clock
- resetn  in  1  synchronous, active-low reset
- in_valid  in  1  fragment present
- in_ready  out  1  fragment accepted when in_valid & in_ready
- in_data  in  DATA_WIDTH  source beat; byte i = bits [8i+7:8i]
- in_offset  in  OFF_W  first valid byte index in in_data
- in_size  in  SIZE_W  fragment length in bytes, 0..BYTES
- in_last  in  1  final fragment of stream; forces flush
- out_valid  out  1  beat available
- out_ready  in  1  writer consumes beat when out_valid & out_ready
- out_data  out  DATA_WIDTH  packed beat, little-endian byte order
- out_keep  out  BYTES  valid-byte mask, contiguous from byte 0
- out_last  out  1  last beat of stream
- fill_level  out  SIZE_W  residual bytes held (0..BYTES-1)
- beat_count  out  COUNT_W  beats emitted since reset, wraps
- size_error  out  1  sticky: some accepted fragment had offset+size > BYTES

Behaviour:
- Reset (resetn=0 at posedge): state=RUN, fill=0, acc=0, out_valid=0, out_data=0, out_keep=0, out_last=0, beat_count=0, size_error=0. Reset mid-stream discards all held bytes and any pending beat; nothing is emitted.
- State machine, two states:
  - RUN: accepts fragments.
  - FLUSH: drains residual bytes after an in_last that overflowed one beat.
- Output register: one stage. out_free = !out_valid | out_ready. A beat is consumed when out_valid & out_ready.
- in_ready = (state==RUN) & out_free. Purely combinational from state and registers plus out_ready; never depends on in_valid.
- Fragment length: eff = min(in_size, BYTES - in_offset).
  - If in_size > BYTES - in_offset, size_error sets and stays set until reset; the truncated fragment is still packed.
- Fragment extraction: frag = in_data >> (8*in_offset), with bytes >= eff zeroed.
- Accepting a fragment:
  - comb = acc | (frag << 8*fill), 2*BYTES wide.
  - nf = fill + eff, range 0..2*BYTES-1.
- Outcomes on accept, decided in this order:
  1. nf >= BYTES and !in_last: load out_data=comb[BYTES-1:0], keep all ones, last=0; acc=comb>>BYTES; fill=nf-BYTES.
  2. in_last and 0 < nf <= BYTES: load comb low, keep=(1<<nf)-1 (all ones when nf==BYTES), last=1; fill=0, acc=0.
  3. in_last and nf > BYTES: load full beat with last=0; acc/fill take the residual; state goes to FLUSH.
  4. in_last and nf==0: no beat emitted; stream ends silently.
  5. Otherwise: acc=comb, fill=nf, no beat.
- FLUSH: when out_free, load acc low with keep=(1<<fill)-1, last=1; fill=0, acc=0; state returns to RUN. Entered only with fill >= 1.
- If out_ready drops while a beat is held: out_valid and out_data/keep/last stay stable until consumed.
- Unused acc bytes are always zero, so OR-merging is safe.
- When a beat is consumed and not replaced in the same cycle, out_valid=0; out_data/keep/last hold their old values.
- beat_count increments on every consumption; wraps modulo 2^COUNT_W.
- Latency: accepted fragment to out_valid is 1 cycle when it completes a beat. Throughput is 1 beat/cycle under continuous out_ready.
- Simultaneous consume and load in one cycle is legal; the new beat replaces the old one with no bubble.

Test Plan:
- DATA_WIDTH=512: four fragments size 16, offsets 0/16/32/48, out_ready=1. -> One beat, 1 cycle after the 4th accept, with bytes 0..63 in source order; keep all ones; last=0; fill_level=0; beat_count=1.
- Fragments size 40 then 40 (offset 0). -> After the 2nd: full beat emitted; fill_level=16; upper 16 residual bytes = bytes 24..39 of the 2nd fragment.
- fill=50, then fragment size 30 with in_last. -> Full beat last=0; FLUSH; next cycle beat keep=0xFFFF, last=1; in_ready low during FLUSH; fill_level returns to 0.
- out_ready held 0 for 5 cycles with a beat pending. -> out_data/keep/last stable; in_ready=0; no beat lost or duplicated; beat_count unchanged until release.
- in_offset=60, in_size=10. -> eff=4, size_error=1 and stays 1; fill_level +4.
- resetn pulsed low with fill=30 and out_valid=1. -> Next cycle out_valid=0, fill_level=0, beat_count=0, size_error=0, state RUN, in_ready=1.
